// File: rtl/row_result_collector_pkg.sv
// rtl/row_result_collector_pkg.sv - shared sizes and state encoding for the row result collector
package row_result_collector_pkg;

    localparam int element_width = 32;
    localparam int max_rows      = 64;
    localparam int addr_width    = $clog2(max_rows);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        COLLECT   = 2'd2
    } state_t;

endpackage

// File: rtl/row_result_collector_if.sv
// rtl/row_result_collector_if.sv - collect, read-out and status signals of the row result collector
interface row_result_collector_if
    import row_result_collector_pkg::*;
    ;

    logic [element_width-1:0] result;
    logic                     decoder_read_now;
    logic                     start_collect;
    logic [31:0]              no_of_rows;
    logic                     collect_busy;
    logic                     write_bank;
    logic                     vector_ready;
    logic                     read_bank;
    logic                     read_en;
    logic [addr_width-1:0]    read_addr;
    logic [element_width-1:0] read_data;
    logic                     read_valid;
    logic                     release_bank;
    logic                     config_error;
    logic                     overflow_error;

    modport master (
        output result, decoder_read_now, start_collect, no_of_rows,
        output read_en, read_addr, release_bank,
        input  collect_busy, write_bank, vector_ready, read_bank,
        input  read_data, read_valid, config_error, overflow_error
    );

    modport slave (
        input  result, decoder_read_now, start_collect, no_of_rows,
        input  read_en, read_addr, release_bank,
        output collect_busy, write_bank, vector_ready, read_bank,
        output read_data, read_valid, config_error, overflow_error
    );

endinterface

// File: rtl/row_result_collector_result_bank_ram.sv
// rtl/row_result_collector_result_bank_ram.sv - both result banks in one dual-port RAM, addressed {bank, index}
module result_bank_ram #(
    parameter int data_width = 32,
    parameter int addr_bits  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [addr_bits-1:0]  wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_bits-1:0]  rd_addr,
    output logic [data_width-1:0] rd_data,
    output logic                  rd_valid
);

    logic [data_width-1:0] mem [2**addr_bits];

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/row_result_collector.sv
// rtl/row_result_collector.sv - ping-pong buffer collecting row dot products into result vectors
module row_result_collector
    import row_result_collector_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    row_result_collector_if.slave bus
);

    state_t                state;
    state_t                state_next;
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_next;
    logic                  write_bank_q;
    logic                  read_bank_q;
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width:0]   rows_latched;
    logic                  config_error_q;
    logic                  overflow_error_q;

    logic                  rows_bad;
    logic                  start_ok;
    logic                  release_ok;
    logic                  write_fire;
    logic                  last_write;
    logic                  rd_en;

    always_comb begin
        rows_bad   = (bus.no_of_rows == 32'd0) || (bus.no_of_rows > 32'(max_rows));
        start_ok   = (state == IDLE) && bus.start_collect && !rows_bad;
        release_ok = bus.release_bank && bank_full[read_bank_q];
        write_fire = (state == COLLECT) && bus.decoder_read_now;
        last_write = write_fire &&
                     ({1'b0, wr_ptr} == rows_latched - {{addr_width{1'b0}}, 1'b1});
        rd_en      = bus.read_en && bank_full[read_bank_q];
    end

    // Collection always writes the bank not held by the consumer, so the
    // set and clear below never touch the same bit in one cycle.
    always_comb begin
        bank_full_next = bank_full;
        if (release_ok) begin
            bank_full_next[read_bank_q] = 1'b0;
        end
        if (last_write) begin
            bank_full_next[write_bank_q] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = bank_full[write_bank_q] ? WAIT_BANK : COLLECT;
                end
            end
            WAIT_BANK: begin
                if (!bank_full_next[write_bank_q]) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (last_write) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bank_full        <= 2'b00;
            write_bank_q     <= 1'b0;
            read_bank_q      <= 1'b0;
            wr_ptr           <= '0;
            rows_latched     <= '0;
            config_error_q   <= 1'b0;
            overflow_error_q <= 1'b0;
        end else begin
            state     <= state_next;
            bank_full <= bank_full_next;
            if (release_ok) begin
                read_bank_q <= ~read_bank_q;
            end
            if (last_write) begin
                write_bank_q <= ~write_bank_q;
            end
            if (start_ok) begin
                rows_latched <= bus.no_of_rows[addr_width:0];
                wr_ptr       <= '0;
            end else if (write_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if ((state == IDLE) && bus.start_collect && rows_bad) begin
                config_error_q <= 1'b1;
            end
            if (bus.decoder_read_now && (state != COLLECT)) begin
                overflow_error_q <= 1'b1;
            end
        end
    end

    result_bank_ram #(
        .data_width (element_width),
        .addr_bits  (addr_width + 1)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (write_fire),
        .wr_addr  ({write_bank_q, wr_ptr}),
        .wr_data  (bus.result),
        .rd_en    (rd_en),
        .rd_addr  ({read_bank_q, bus.read_addr}),
        .rd_data  (bus.read_data),
        .rd_valid (bus.read_valid)
    );

    always_comb begin
        bus.collect_busy   = (state != IDLE);
        bus.write_bank     = write_bank_q;
        bus.read_bank      = read_bank_q;
        bus.vector_ready   = bank_full[read_bank_q];
        bus.config_error   = config_error_q;
        bus.overflow_error = overflow_error_q;
    end

endmodule
